// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and the fetch buffer entry type
package fetch_pkg;
  localparam int FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_cycle_fifo.sv
// fetch_fifo: synchronous FIFO with flush, used for both the instruction buffer and the PC tag queue
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type T = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  output T                         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr] <= din;
  end
  assign dout = mem[rd];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  no_overflow: assert property (@(posedge clk) disable iff (rst || flush) !(push && full && !pop));
endmodule

// File: rtl/fetch_cycle.sv
// fetch_cycle: fetch stage with credit-limited imem requests, PC-tagged buffer and redirect flush
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched/perf_dropped/perf_stall_cycles outputs.
module fetch_cycle
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_dropped,
  output logic [XLEN-1:0] perf_stall_cycles,
`endif
  output logic            inst_valid,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] PC_out
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [XLEN-1:0] fetch_pc, tag_head;
  logic [CW-1:0] outstanding, drop, entry_count, tag_count;
  logic hs, accept, pop, entry_empty, entry_full, tag_full, tag_empty;
  fetch_entry_t head;
  logic unused;
  assign imem_req = !rst && !redirect_valid && ({1'b0, outstanding} + {1'b0, entry_count} < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = fetch_pc;
  assign hs = imem_req && imem_ready;
  // responses still owed from before a redirect are swallowed while drop is nonzero
  assign accept = imem_rvalid && drop == '0 && !redirect_valid;
  assign pop = inst_valid && !stall;
  assign inst_valid = !entry_empty;
  assign instruction = inst_valid ? head.instr : NOP_INSTR;
  assign PC_out = inst_valid ? head.pc : '0;
  assign unused = ^{tag_full, tag_empty, tag_count, entry_full, redirect_pc[1:0]};
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [XLEN-1:0])) tag_q (
    .clk(clk), .rst(rst), .flush(redirect_valid), .push(hs), .din(fetch_pc), .pop(accept),
    .dout(tag_head), .count(tag_count), .full(tag_full), .empty(tag_empty)
  );
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(fetch_entry_t)) entry_q (
    .clk(clk), .rst(rst), .flush(redirect_valid), .push(accept), .din('{pc: tag_head, instr: imem_rdata}),
    .pop(pop), .dout(head), .count(entry_count), .full(entry_full), .empty(entry_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
    end else begin
      outstanding <= outstanding + CW'(hs) - CW'(imem_rvalid);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        drop <= outstanding - CW'(imem_rvalid);
      end else begin
        if (hs) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
        if (imem_rvalid && drop != '0) drop <= drop - CW'(1);
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  function automatic logic [XLEN-1:0] sat_add(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[XLEN] ? '1 : s[XLEN-1:0];
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, XLEN'(accept));
      perf_dropped <= sat_add(perf_dropped, XLEN'(imem_rvalid && !accept) + (redirect_valid ? XLEN'(entry_count) : '0));
      perf_stall_cycles <= sat_add(perf_stall_cycles, XLEN'(inst_valid && stall));
    end
  end
`endif
endmodule

// File: tb/tb_fetch_cycle.sv
// tb_fetch_cycle: vector table, directed corner sequences and random stream checked against an in-order PC stream model
module tb_fetch_cycle;
  import fetch_pkg::*;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam int DEPTH = 2;
  logic clk = 0, rst, imem_req, imem_ready, imem_rvalid, stall, redirect_valid, inst_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, PC_out;
  always #5 clk = ~clk;
  fetch_cycle #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .instruction(instruction), .PC_out(PC_out)
  );
  int total = 0, bad = 0, cyc = 0, pops = 0, lat_min = 1, lat_max = 1;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t mq[$];
  logic [31:0] next_exp = RST_PC;
  typedef struct {logic stall; logic req; logic [31:0] addr; logic iv; logic [31:0] pc;} vec_t;
  vec_t tab[8];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // one clock: drive at negedge, let memory respond, sample, run the stream model
  task automatic step(input logic s_rst, input logic s_stall, input logic s_redir, input logic [31:0] s_rpc, input logic s_ready);
    @(negedge clk);
    rst = s_rst; stall = s_stall; redirect_valid = s_redir; redirect_pc = s_rpc; imem_ready = s_ready;
    imem_rvalid = !s_rst && mq.size() > 0 && mq[0].due <= cyc;
    imem_rdata = imem_rvalid ? mem_word(mq[0].addr) : $urandom;
    #1;
    if (s_rst) begin
      mq.delete();
      next_exp = RST_PC;
    end else begin
      if (imem_rvalid) void'(mq.pop_front());
      if (imem_req && imem_ready) mq.push_back('{imem_addr, cyc + $urandom_range(lat_max, lat_min)});
      chk("credit_limit", 32'(mq.size() <= DEPTH), 1);
      if (s_redir) next_exp = s_rpc & ~32'h3;
      else if (inst_valid) begin
        chk("stream_pc", PC_out, next_exp);
        chk("stream_instr", instruction, mem_word(next_exp));
        if (!s_stall) begin
          next_exp += 4;
          pops++;
        end
      end else begin
        chk("empty_instr", instruction, NOP_INSTR);
        chk("empty_pc", PC_out, 0);
      end
    end
    cyc++;
  endtask
  task automatic do_reset();
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask
  initial begin
    logic found;
    rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0; imem_ready = 1; imem_rvalid = 0; imem_rdata = 0;
    tab[0] = '{0, 1, 32'h100, 0, 32'h0};
    tab[1] = '{0, 1, 32'h104, 0, 32'h0};
    tab[2] = '{0, 0, 32'h0,   1, 32'h100};
    tab[3] = '{0, 1, 32'h108, 1, 32'h104};
    tab[4] = '{0, 1, 32'h10C, 0, 32'h0};
    tab[5] = '{0, 0, 32'h0,   1, 32'h108};
    tab[6] = '{0, 1, 32'h110, 1, 32'h10C};
    tab[7] = '{0, 1, 32'h114, 0, 32'h0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(0, tab[i].stall, 0, 0, 1);
      chk("tab_req", imem_req, tab[i].req);
      if (tab[i].req) chk("tab_addr", imem_addr, tab[i].addr);
      chk("tab_valid", inst_valid, tab[i].iv);
      chk("tab_pc", PC_out, tab[i].pc);
    end
    // decode stall holds the head and throttles requests
    do_reset();
    run(2);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 1);
      chk("stall_pc", PC_out, 32'h100);
      chk("stall_noreq", imem_req, 0);
    end
    run(10);
    // redirect with two slow responses in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    run(2);
    chk("two_outstanding", mq.size(), 2);
    step(0, 0, 1, 32'h400, 1);
    found = 0;
    for (int i = 0; i < 15 && !found; i++) begin
      step(0, 0, 0, 0, 1);
      if (inst_valid) begin
        found = 1;
        chk("redir_first_pc", PC_out, 32'h400);
      end
    end
    if (!found) chk("redir_timeout", 0, 1);
    // redirect coincident with a response while decode stalls on a buffered entry
    do_reset();
    lat_min = 1; lat_max = 1;
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 32'h400, 1);
    chk("coinc_rvalid", imem_rvalid, 1);
    chk("coinc_noreq", imem_req, 0);
    step(0, 1, 0, 0, 1);
    chk("coinc_req", imem_req, 1);
    chk("coinc_addr", imem_addr, 32'h400);
    chk("coinc_flushed", inst_valid, 0);
    run(6);
    // misaligned redirect near the top of the address space, then wrap
    do_reset();
    step(0, 0, 1, 32'hFFFF_FFFE, 1);
    step(0, 0, 0, 0, 1);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0, 1);
    chk("wrap_req", imem_req, 1);
    chk("wrap_addr1", imem_addr, 32'h0);
    run(6);
    // reset mid-stream with two requests outstanding
    do_reset();
    lat_min = 3; lat_max = 3;
    run(2);
    chk("rst_two_out", mq.size(), 2);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_req", imem_req, 1);
    chk("rst_valid", inst_valid, 0);
    run(8);
    // random traffic
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_redir;
      logic [31:0] rpc;
      r_rst = ($urandom % 250) == 0;
      r_redir = ($urandom % 30) == 0;
      rpc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : ($urandom & 32'h0000_FFFF);
      step(r_rst, ($urandom % 3) == 0, r_redir, rpc, ($urandom % 4) != 0);
    end
    chk("progress", 32'(pops > 300), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
